// File: rtl/instr_sequencer_if.sv
// Host/CPU-facing bundle of the instruction sequencer: program load port,
// run control, and the registered instruction stream.
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
);
  logic                   load_valid;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   load_last;
  logic                   load_ready;
  logic                   start;
  logic                   stall;
  logic                   clear;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;

  modport master (
    output load_valid, load_data, load_last, start, stall, clear,
    input  load_ready, instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  load_valid, load_data, load_last, start, stall, clear,
    output load_ready, instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: loads a program into a 2^PC_BITS-entry store and
// plays it out one word per clock until a halt word or the end of the program.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '1,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = '0
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);
  localparam int DEPTH = 1 << PC_BITS;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [PC_BITS:0]       pc_q, pc_d;
  logic [PC_BITS:0]       count_q, count_d;
  logic [PC_BITS-1:0]     wr_ptr_q, wr_ptr_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   vld_q, vld_d;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic                   load_hs;
  logic                   mem_we;
  logic [INSTR_WIDTH-1:0] fetch_w;

  // count only reaches DEPTH, so its MSB alone flags a full store
  assign bus.load_ready  = ((state_q == IDLE) || (state_q == LOAD)) && !count_q[PC_BITS];
  assign load_hs         = bus.load_valid & bus.load_ready;
  assign mem_we          = load_hs & ~bus.clear;
  assign fetch_w         = mem[pc_q[PC_BITS-1:0]];
  assign bus.instruction = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q[PC_BITS-1:0];
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    instr_d  = NOP_WORD;
    vld_d    = 1'b0;
    if (bus.clear) begin
      state_d  = IDLE;
      pc_d     = '0;
      count_d  = '0;
      wr_ptr_d = '0;
    end else begin
      unique case (state_q)
        IDLE, LOAD: begin
          if (load_hs) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            count_d  = count_q + 1'b1;
            state_d  = (bus.load_last || count_d[PC_BITS]) ? IDLE : LOAD;
          end else if (state_q == IDLE && bus.start && count_q != '0) begin
            pc_d    = '0;
            state_d = RUN;
          end
        end
        RUN: begin
          if (!bus.stall) begin
            // pc == count uses the full-width pc so a 32-word program ends cleanly
            if (fetch_w == HALT_WORD || pc_q == count_q) begin
              state_d = DONE;
            end else begin
              instr_d = fetch_w;
              vld_d   = 1'b1;
              pc_d    = pc_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            pc_d    = '0;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      instr_q  <= NOP_WORD;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      instr_q  <= instr_d;
      vld_q    <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr_q] <= bus.load_data;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Instruction source for the simple CPU: the producing end of its 20-bit instruction input.
- Accepts a program through a valid/ready load port into an internal 32-entry instruction store.
- On start, it plays the program out one instruction per clock, with stall support, and ends on a halt word or at the end of the program.
- Sits between the testbench or host loader and the CPU's instruction port.

Parameters:
- INSTR_WIDTH, 20, instruction width.
- PC_BITS, 5, program counter width; store depth is 2^PC_BITS = 32.
- HALT_WORD, 20'hFFFFF, encoding that terminates execution; it is never emitted.
- NOP_WORD, 20'h00000, word driven whenever no valid instruction is presented.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-low.
- load_valid  in  1  load word present.
- load_data  in  INSTR_WIDTH  program word.
- load_last  in  1  marks the final word of the program (qualified by a load handshake).
- load_ready  out  1  sequencer can accept a word.
- start  in  1  begin execution from pc 0.
- stall  in  1  hold execution this cycle.
- clear  in  1  discard the program and abort execution.
- instruction  out  INSTR_WIDTH  registered instruction to the CPU.
- instr_valid  out  1  instruction holds a real program word.
- pc  out  PC_BITS  address of the next word to fetch.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst=0, asynchronous) sets:
  - state=IDLE, pc=0, wr_ptr=0, count=0 (count is PC_BITS+1 bits);
  - instruction=NOP_WORD, instr_valid=0, done=0, busy=0.
  - Store contents are not reset.
  - Reset mid-RUN forces NOP out immediately and loses the program (count=0).
- States are IDLE, LOAD, RUN and DONE.
- load_ready = (state is IDLE or LOAD) and count<32. It is combinational.
- A load handshake is load_valid & load_ready at a clock edge. On a handshake:
  - mem[wr_ptr] is written with load_data;
  - wr_ptr increments and count increments;
  - IDLE moves to LOAD.
- A handshake with load_last=1, or the handshake that makes count reach 32, returns the FSM to IDLE.
  - load_ready is then 0 once count=32. Extra words are not accepted and are not written.
- New loads from IDLE append at wr_ptr. Only clear rewinds the store.
- start is acted on only in IDLE (with count>0) or in DONE.
  - start in IDLE with count=0 is ignored.
  - start in LOAD or RUN is ignored.
  - In IDLE, a load handshake and start in the same cycle: the load wins and start is dropped.
- Start edge: pc<=0 and state<=RUN. No word is emitted on this edge.
- RUN, stall=0 edge, fetching word w=mem[pc]:
  - If w==HALT_WORD: instruction<=NOP_WORD, instr_valid<=0, state<=DONE.
  - Else if pc==count (program exhausted): same as halt.
  - Else: instruction<=w, instr_valid<=1, pc<=pc+1.
- RUN, stall=1 edge: instruction<=NOP_WORD, instr_valid<=0, pc held.
- Latency: the first instruction is valid 2 edges after start is sampled. Each subsequent unstalled edge presents the next word.
- DONE holds done=1, instruction=NOP_WORD and instr_valid=0.
  - start in DONE re-runs the retained program from pc 0.
- clear is accepted in any state and has priority over start, load and stall.
  - It sets state=IDLE, count=0, wr_ptr=0, pc=0, instruction=NOP_WORD, instr_valid=0 on the next edge.
- busy = (state==RUN). done = (state==DONE). Both are decoded from registered state.
- pc never wraps in RUN because pc≤count≤32. With a full store, the pc==count check uses the (PC_BITS+1)-bit comparison.

Test Plan:
- Load 3 words (0x12345, 0x0ABCD, 0x00F0F with load_last), then pulse start:
  - instruction is 0x12345, 0x0ABCD, 0x00F0F on three consecutive cycles with instr_valid=1;
  - then NOP, instr_valid=0, done=1;
  - pc sequence is 1, 2, 3.
- Load 0x11111, 0xFFFFF, 0x22222, then start:
  - only 0x11111 is emitted;
  - the next cycle gives done=1; 0x22222 never appears.
- Run the 3-word program with stall=1 on the second execution cycle:
  - the sequence is 0x12345, NOP (valid=0), 0x0ABCD, 0x00F0F;
  - pc holds at 1 during the stall.
- Load 32 words without load_last:
  - load_ready drops after the 32nd handshake;
  - a 33rd load_valid is not written;
  - a full run emits all 32 words, then done.
- Assert rst=0 mid-RUN (third instruction):
  - instruction=NOP and instr_valid=0 immediately, without waiting for a clock;
  - after release, start is ignored (count=0) and load_ready=1.
- In DONE, pulse start:
  - the program replays from 0x12345.
- In DONE, pulse clear:
  - state is IDLE, load_ready=1;
  - a subsequent start with no new load is ignored.
